// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES key schedule producer for the shared round-key word memory
// Ports:
//   ap_clk, ap_rst_n               clock, asynchronous active-low reset
//   ap_start/ap_done/ap_idle/ap_ready  block handshake (done/ready pulse together)
//   nk                             key length in words (6, 8, anything else = 4)
//   key_address0/key_ce0/key_q0    key byte ROM read, 1-cycle latency
//   sbox_address0/sbox_ce0/sbox_q0 external S-box ROM read, 1-cycle latency
//   word_address0/word_ce0/word_q0 word memory read port, 1-cycle latency
//   word_address1/word_ce1/word_we1/word_d1  word memory write port
//   word memory layout: address = row*120 + col, byte in bits [7:0]
module key_expansion (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [3:0]  nk,
    output logic [4:0]  key_address0,
    output logic        key_ce0,
    input  logic [31:0] key_q0,
    output logic [7:0]  sbox_address0,
    output logic        sbox_ce0,
    input  logic [7:0]  sbox_q0,
    output logic [8:0]  word_address0,
    output logic        word_ce0,
    input  logic [31:0] word_q0,
    output logic [8:0]  word_address1,
    output logic        word_ce1,
    output logic        word_we1,
    output logic [31:0] word_d1
);
    typedef enum logic [2:0] {S_IDLE, S_COPY, S_SUB, S_XW, S_DONE} state_t;
    state_t state, state_nxt;

    logic [3:0] nk_r;
    logic [4:0] cnt;        // position inside COPY (key byte) or SUB/XW (0..4)
    logic [5:0] j;          // column being produced
    logic [3:0] jm;         // j mod nk, kept incrementally to avoid a divider
    logic       col_sub;    // current column uses tmp from a SUB phase
    logic       col_rot;    // current column's SUB is the rotated/rcon flavour
    logic [7:0] rcon;
    logic [7:0] tmp  [4];
    logic [7:0] prev [4];   // last written column, one byte per row

    // Every write is the registered echo of a read issued the cycle before.
    logic       wr_valid;
    logic       wr_xw;
    logic [1:0] wr_row;
    logic [8:0] wr_addr;
    logic [7:0] wr_byte;

    logic [3:0] nk_sel;
    logic [5:0] ncol;
    logic       copy_last;
    logic       phase_last;
    logic [5:0] j_inc;
    logic [3:0] jm_inc;
    logic [3:0] jm_nxt;
    logic       nxt_sub;
    logic       issue_wr;
    logic [8:0] wr_addr_nxt;
    logic [1:0] cap_idx;
    logic [1:0] sb_idx;
    logic [7:0] rcon_x2;
    logic       unused_ok;

    function automatic logic [8:0] row_off(input logic [1:0] r);
        case (r)
            2'd0:    row_off = 9'd0;
            2'd1:    row_off = 9'd120;
            2'd2:    row_off = 9'd240;
            default: row_off = 9'd360;
        endcase
    endfunction

    assign nk_sel     = (nk == 4'd6) ? 4'd6 : (nk == 4'd8) ? 4'd8 : 4'd4;
    assign ncol       = (nk_r == 4'd6) ? 6'd52 : (nk_r == 4'd8) ? 6'd60 : 6'd44;
    assign copy_last  = ({1'b0, cnt} == ({nk_r, 2'b00} - 6'd1));
    assign phase_last = (cnt == 5'd4);
    assign j_inc      = j + 6'd1;
    assign jm_inc     = jm + 4'd1;
    assign jm_nxt     = (jm_inc == nk_r) ? 4'd0 : jm_inc;
    assign nxt_sub    = (jm_nxt == 4'd0) || ((nk_r == 4'd8) && (jm_nxt == 4'd4));
    assign issue_wr   = (state == S_COPY) || ((state == S_XW) && !phase_last);
    assign wr_addr_nxt = (state == S_COPY) ? row_off(cnt[1:0]) + {6'b0, cnt[4:2]}
                                           : row_off(cnt[1:0]) + {3'b0, j};
    assign cap_idx    = cnt[1:0] - 2'd1;
    assign sb_idx     = col_rot ? cnt[1:0] + 2'd1 : cnt[1:0];
    assign rcon_x2    = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    assign wr_byte    = wr_xw ? (word_q0[7:0] ^ (col_sub ? tmp[wr_row] : prev[wr_row]))
                              : key_q0[7:0];
    assign unused_ok  = &{1'b0, key_q0[31:8], word_q0[31:8]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ap_start)   state_nxt = S_COPY;
            S_COPY: if (copy_last)  state_nxt = S_SUB;   // j = nk is always a rotated column
            S_SUB:  if (phase_last) state_nxt = S_XW;
            S_XW:   if (phase_last) state_nxt = (j_inc == ncol) ? S_DONE
                                              : (nxt_sub ? S_SUB : S_XW);
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ap_idle       = (state == S_IDLE) && !ap_start;
        ap_done       = (state == S_DONE);
        ap_ready      = (state == S_DONE);
        key_ce0       = (state == S_COPY);
        key_address0  = (state == S_COPY) ? cnt : 5'd0;
        sbox_ce0      = (state == S_SUB) && !phase_last;
        sbox_address0 = sbox_ce0 ? prev[sb_idx] : 8'd0;
        word_ce0      = (state == S_XW) && !phase_last;
        word_address0 = word_ce0 ? row_off(cnt[1:0]) + {3'b0, j - {2'b00, nk_r}} : 9'd0;
        word_ce1      = wr_valid;
        word_we1      = wr_valid;
        word_address1 = wr_addr;
        word_d1       = wr_valid ? {24'b0, wr_byte} : 32'd0;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            nk_r     <= 4'd4;
            cnt      <= 5'd0;
            j        <= 6'd0;
            jm       <= 4'd0;
            col_sub  <= 1'b0;
            col_rot  <= 1'b0;
            rcon     <= 8'h01;
            wr_valid <= 1'b0;
            wr_xw    <= 1'b0;
            wr_row   <= 2'd0;
            wr_addr  <= 9'd0;
            for (int i = 0; i < 4; i++) begin
                tmp[i]  <= 8'd0;
                prev[i] <= 8'd0;
            end
        end else begin
            wr_valid <= issue_wr;
            wr_xw    <= (state == S_XW);
            wr_row   <= cnt[1:0];
            wr_addr  <= issue_wr ? wr_addr_nxt : 9'd0;
            if (wr_valid) prev[wr_row] <= wr_byte;
            case (state)
                S_IDLE: if (ap_start) begin
                    nk_r    <= nk_sel;
                    cnt     <= 5'd0;
                    j       <= 6'd0;
                    jm      <= 4'd0;
                    rcon    <= 8'h01;
                    col_sub <= 1'b0;
                    col_rot <= 1'b0;
                end
                S_COPY: if (copy_last) begin
                    cnt     <= 5'd0;
                    j       <= {2'b00, nk_r};
                    jm      <= 4'd0;
                    col_sub <= 1'b1;
                    col_rot <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
                S_SUB: begin
                    cnt <= phase_last ? 5'd0 : cnt + 5'd1;
                    // S-box data for read n arrives at cnt n+1
                    if (cnt != 5'd0)
                        tmp[cap_idx] <= sbox_q0 ^ ((col_rot && cap_idx == 2'd0) ? rcon : 8'h00);
                    if (phase_last && col_rot) rcon <= rcon_x2;
                end
                S_XW: begin
                    cnt <= phase_last ? 5'd0 : cnt + 5'd1;
                    if (phase_last) begin
                        j       <= j_inc;
                        jm      <= jm_nxt;
                        col_sub <= nxt_sub;
                        col_rot <= (jm_nxt == 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - directed bench for key_expansion with ROM/RAM models and a reference schedule
module tb_key_expansion;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [3:0]  nk = 4'd0;
    logic [4:0]  key_address0;
    logic        key_ce0;
    logic [31:0] key_q0 = 32'd0;
    logic [7:0]  sbox_address0;
    logic        sbox_ce0;
    logic [7:0]  sbox_q0 = 8'd0;
    logic [8:0]  word_address0;
    logic        word_ce0;
    logic [31:0] word_q0 = 32'd0;
    logic [8:0]  word_address1;
    logic        word_ce1, word_we1;
    logic [31:0] word_d1;

    key_expansion dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .nk(nk),
        .key_address0(key_address0), .key_ce0(key_ce0), .key_q0(key_q0),
        .sbox_address0(sbox_address0), .sbox_ce0(sbox_ce0), .sbox_q0(sbox_q0),
        .word_address0(word_address0), .word_ce0(word_ce0), .word_q0(word_q0),
        .word_address1(word_address1), .word_ce1(word_ce1), .word_we1(word_we1),
        .word_d1(word_d1)
    );

    always #5 ap_clk = ~ap_clk;

    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [7:0]  sbox_tab [256];
    logic [7:0]  key_mem  [32];
    logic [31:0] wmem     [480];
    logic [31:0] ref_w    [60];
    logic [7:0]  sb_addr  [64];
    int          sb_n = 0;
    int          viol = 0;
    int          cur_ncol = 44;
    logic        clr = 1'b0;
    int          n_chk = 0;
    int          n_bad = 0;
    int          lat;

    // memory models plus write-port protocol monitor
    always @(posedge ap_clk) begin
        if (clr) begin
            for (int a = 0; a < 480; a++) wmem[a] <= 32'hdeadbeef;
            viol <= 0;
            sb_n <= 0;
        end else begin
            if (key_ce0) key_q0 <= {24'ha5a5a5, key_mem[key_address0]};
            if (sbox_ce0) begin
                sbox_q0 <= sbox_tab[sbox_address0];
                if (sb_n < 64) sb_addr[sb_n] <= sbox_address0;
                sb_n <= sb_n + 1;
            end
            if (word_ce0) word_q0 <= {24'h5a5a5a, wmem[word_address0][7:0]};
            if (word_we1) begin
                if (!word_ce1 || word_address1 >= 9'd420 || (int'(word_address1) % 120) >= cur_ncol
                    || word_d1[31:8] != 24'd0 || (word_ce0 && word_address0 == word_address1))
                    viol <= viol + 1;
                if (word_ce1 && word_address1 < 9'd480) wmem[word_address1] <= word_d1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand(input int k, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < k; i++) ref_w[i] = key[255-32*i -: 32];
        for (int i = k; i < 4*(k+7); i++) begin
            t = ref_w[i-1];
            if (i % k == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (k == 8 && i % k == 4) begin
                t = sub_word(t);
            end
            ref_w[i] = ref_w[i-k] ^ t;
        end
    endtask

    function automatic logic [31:0] col_val(input int c);
        return {wmem[c][7:0], wmem[120+c][7:0], wmem[240+c][7:0], wmem[360+c][7:0]};
    endfunction

    task automatic prep(input logic [255:0] key, input int k);
        for (int b = 0; b < 32; b++) key_mem[b] = key[255-8*b -: 8];
        expand(k, key);
        cur_ncol = 4*(k+7);
        @(negedge ap_clk); clr = 1'b1;
        @(negedge ap_clk); clr = 1'b0;
    endtask

    task automatic compare_all(input string run);
        for (int c = 0; c < cur_ncol; c++)
            check($sformatf("%s_col%0d", run, c), col_val(c), ref_w[c]);
        check({run, "_protocol_viol"}, viol, 0);
    endtask

    // start a run, scramble nk after the start cycle, return start->done latency
    task automatic run(input logic [3:0] k, input bit hold, output int l);
        @(negedge ap_clk);
        nk = k;
        ap_start = 1'b1;
        l = 0;
        while (l < 1000) begin
            @(posedge ap_clk); #1;
            l++;
            if (l == 1) begin
                check("idle_drop", ap_idle, 1'b0);
                if (!hold) ap_start = 1'b0;
                nk = k ^ 4'd8;
            end
            if (ap_done) break;
        end
        check("done_seen", ap_done, 1'b1);
        check("ready_with_done", ap_ready, 1'b1);
        @(posedge ap_clk); #1;
        check("done_one_cycle", {ap_done, ap_ready}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_tab[i] = SBOX_FLAT[2047-8*i -: 8];
        for (int b = 0; b < 32; b++) key_mem[b] = 8'd0;

        // reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_outs", {ap_done, ap_ready, key_ce0, sbox_ce0, word_ce0, word_ce1, word_we1,
                           key_address0, sbox_address0, word_address0, word_address1}, 0);
        check("rst_d1", word_d1, 32'd0);
        check("rst_idle", ap_idle, 1'b1);
        @(negedge ap_clk); ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("post_rst_idle", ap_idle, 1'b1);

        // AES-128
        prep(KEY128, 4);
        run(4'd4, 1'b0, lat);
        check("aes128_latency", lat, 267);
        check("aes128_col4", col_val(4), 32'ha0fafe17);
        check("aes128_col43", col_val(43), 32'hb6630ca6);
        compare_all("aes128");

        // AES-192
        prep(KEY192, 6);
        run(4'd6, 1'b0, lat);
        check("aes192_latency", lat, 295);
        check("aes192_col51", col_val(51), 32'h01002202);
        compare_all("aes192");

        // AES-256, including the plain SubWord at j=12
        prep(KEY256, 8);
        run(4'd8, 1'b0, lat);
        check("aes256_latency", lat, 358);
        check("aes256_col59", col_val(59), 32'h706c631e);
        check("aes256_sbox_reads", sb_n, 52);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("aes256_j8_sbox%0d", i), sb_addr[i], ref_w[7][31-8*((i+1)%4) -: 8]);
            check($sformatf("aes256_j12_sbox%0d", i), sb_addr[4+i], ref_w[11][31-8*i -: 8]);
        end
        compare_all("aes256");

        // back-to-back with ap_start held through DONE
        prep(KEY128, 4);
        run(4'd4, 1'b1, lat);
        check("b2b_first_latency", lat, 267);
        check("b2b_idle_low_with_start", ap_idle, 1'b0);
        run(4'd4, 1'b0, lat);
        check("b2b_second_latency", lat, 267);
        compare_all("b2b");

        // reset during XW of column 20
        prep(KEY128, 4);
        @(negedge ap_clk); nk = 4'd4; ap_start = 1'b1;
        @(posedge ap_clk); #1; ap_start = 1'b0;
        lat = 0;
        while (lat < 500 && !(word_we1 && word_address1 == 9'd20)) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check("col20_write_seen", {word_we1, word_ce0}, 2'b11);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async_rst_enables", {key_ce0, sbox_ce0, word_ce0, word_ce1, word_we1}, 5'd0);
        @(negedge ap_clk); ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("rst_release_idle", ap_idle, 1'b1);
        prep(KEY128, 4);
        run(4'd4, 1'b0, lat);
        check("restart_latency", lat, 267);
        compare_all("restart");

        // illegal nk behaves as 4
        prep(KEY128, 4);
        run(4'd5, 1'b0, lat);
        check("nk5_latency", lat, 267);
        compare_all("nk5");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
